// File: rtl/ttt_turn_ctrl.sv
// ttt_turn_ctrl: turn sequencer and move arbiter in front of the tictactoe core.
// Accepts X/O move requests over req/ack, enforces turn order, issues one-cycle
// move commands to the core and tracks move count, win, draw and AI faults.
// Optional feature: define ALT_START_EN to alternate the starting player
// (X, O, X, ...) on every new_game; without it every game starts with X.
module ttt_turn_ctrl #(
   parameter int unsigned RSP_TIMEOUT = 16,
   parameter int unsigned MAX_MOVES   = 9
) (
   input  logic       i_clk,
   input  logic       i_reset,
   // player X
   input  logic       i_px_req,
   input  logic [1:0] i_px_row,
   input  logic [1:0] i_px_col,
   output logic       o_px_ack,
   // player O
   input  logic       i_po_req,
   input  logic [1:0] i_po_row,
   input  logic [1:0] i_po_col,
   output logic       o_po_ack,
   output logic       o_move_err,
   // game control
   input  logic       i_ai_mode,
   input  logic       i_new_game,
   // core interface
   output logic       o_core_valid,
   output logic [1:0] o_core_xoro,
   output logic [1:0] o_core_row,
   output logic [1:0] o_core_col,
   output logic       o_core_ai_en,
   input  logic       i_core_rsp,
   input  logic       i_core_err,
   input  logic [1:0] i_core_win,
   // status
   output logic [1:0] o_turn,
   output logic [3:0] o_move_cnt,
   output logic       o_game_over,
   output logic [1:0] o_winner,
   output logic       o_draw,
   output logic       o_ai_fault
);

   localparam int unsigned TMO_W = $clog2(RSP_TIMEOUT);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(RSP_TIMEOUT - 1);
   localparam logic [3:0] CNT_MAX = 4'(MAX_MOVES);

   localparam logic [1:0] TURN_NONE = 2'b00;
   localparam logic [1:0] TURN_X    = 2'b01;
   localparam logic [1:0] TURN_O    = 2'b10;

   typedef enum logic [1:0] {
      StWaitMove,
      StIssue,
      StWaitRsp,
      StOver
   } state_e;

   state_e           r_state;
   logic [1:0]       r_turn;
   logic [3:0]       r_move_cnt;
   logic             r_game_over;
   logic [1:0]       r_winner;
   logic             r_draw;
   logic             r_ai_fault;
   logic             r_px_ack;
   logic             r_po_ack;
   logic             r_move_err;
   logic             r_core_valid;
   logic [1:0]       r_core_xoro;
   logic [1:0]       r_core_row;
   logic [1:0]       r_core_col;
   logic             r_core_ai_en;
   logic             r_cur_o;     // move in flight belongs to O
   logic             r_cur_ai;    // move in flight is an AI move
   logic [TMO_W-1:0] r_tmo;

   logic             w_px_take;
   logic             w_po_take;
   logic             w_tmo_hit;
   logic             w_win_hit;
   logic             w_reject;
   logic [3:0]       w_cnt_inc;
   logic [1:0]       w_start_next;

   // A requester whose ack is showing this cycle is still holding its old
   // request; skip it for one cycle so a rejected move is not re-issued.
   assign w_px_take = i_px_req & ~r_px_ack;
   assign w_po_take = i_po_req & ~r_po_ack;
   assign w_tmo_hit = (r_tmo == TMO_LAST);
   assign w_win_hit = (i_core_win == TURN_X) || (i_core_win == TURN_O);
   assign w_reject  = i_core_rsp ? i_core_err : 1'b1;
   assign w_cnt_inc = r_move_cnt + 4'd1;

`ifdef ALT_START_EN
   logic r_alt_o;  // current game was started by O

   // Starting-player toggle, flipped by every new_game.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_alt_o <= 1'b0;
      end else if (i_new_game) begin
         r_alt_o <= ~r_alt_o;
      end
   end

   assign w_start_next = r_alt_o ? TURN_X : TURN_O;
`else
   assign w_start_next = TURN_X;
`endif

   // Main turn FSM; every output is registered here.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state      <= StWaitMove;
         r_turn       <= TURN_X;
         r_move_cnt   <= 4'd0;
         r_game_over  <= 1'b0;
         r_winner     <= TURN_NONE;
         r_draw       <= 1'b0;
         r_ai_fault   <= 1'b0;
         r_px_ack     <= 1'b0;
         r_po_ack     <= 1'b0;
         r_move_err   <= 1'b0;
         r_core_valid <= 1'b0;
         r_core_xoro  <= 2'b00;
         r_core_row   <= 2'b00;
         r_core_col   <= 2'b00;
         r_core_ai_en <= 1'b0;
         r_cur_o      <= 1'b0;
         r_cur_ai     <= 1'b0;
         r_tmo        <= '0;
      end else begin
         // pulse outputs default low
         r_px_ack     <= 1'b0;
         r_po_ack     <= 1'b0;
         r_move_err   <= 1'b0;
         r_core_valid <= 1'b0;
         r_core_xoro  <= 2'b00;
         r_core_row   <= 2'b00;
         r_core_col   <= 2'b00;
         r_core_ai_en <= 1'b0;

         if (i_new_game) begin
            // wins over everything, including a verdict arriving this cycle
            r_state     <= StWaitMove;
            r_turn      <= w_start_next;
            r_move_cnt  <= 4'd0;
            r_game_over <= 1'b0;
            r_winner    <= TURN_NONE;
            r_draw      <= 1'b0;
            r_ai_fault  <= 1'b0;
            r_tmo       <= '0;
         end else begin
            unique case (r_state)
               StWaitMove: begin
                  if (r_turn == TURN_X) begin
                     if (w_px_take) begin
                        r_cur_o      <= 1'b0;
                        r_cur_ai     <= 1'b0;
                        r_core_valid <= 1'b1;
                        r_core_xoro  <= TURN_X;
                        r_core_row   <= i_px_row;
                        r_core_col   <= i_px_col;
                        r_state      <= StIssue;
                     end
                  end else if (r_turn == TURN_O) begin
                     if (i_ai_mode) begin
                        r_cur_o      <= 1'b1;
                        r_cur_ai     <= 1'b1;
                        r_core_valid <= 1'b1;
                        r_core_xoro  <= TURN_O;
                        r_core_ai_en <= 1'b1;
                        r_state      <= StIssue;
                     end else if (w_po_take) begin
                        r_cur_o      <= 1'b1;
                        r_cur_ai     <= 1'b0;
                        r_core_valid <= 1'b1;
                        r_core_xoro  <= TURN_O;
                        r_core_row   <= i_po_row;
                        r_core_col   <= i_po_col;
                        r_state      <= StIssue;
                     end
                  end
               end

               StIssue: begin
                  r_tmo   <= '0;
                  r_state <= StWaitRsp;
               end

               StWaitRsp: begin
                  if (i_core_rsp || w_tmo_hit) begin
                     if (w_reject) begin
                        if (r_cur_ai) begin
                           // the AI cannot retry: O forfeits
                           r_ai_fault  <= 1'b1;
                           r_game_over <= 1'b1;
                           r_winner    <= TURN_X;
                           r_turn      <= TURN_NONE;
                           r_state     <= StOver;
                        end else begin
                           r_px_ack   <= ~r_cur_o;
                           r_po_ack   <= r_cur_o;
                           r_move_err <= 1'b1;
                           r_state    <= StWaitMove;
                        end
                     end else begin
                        r_move_cnt <= w_cnt_inc;
                        if (!r_cur_ai) begin
                           r_px_ack <= ~r_cur_o;
                           r_po_ack <= r_cur_o;
                        end
                        if (w_win_hit) begin
                           r_winner    <= i_core_win;
                           r_game_over <= 1'b1;
                           r_turn      <= TURN_NONE;
                           r_state     <= StOver;
                        end else if (w_cnt_inc == CNT_MAX) begin
                           r_draw      <= 1'b1;
                           r_game_over <= 1'b1;
                           r_turn      <= TURN_NONE;
                           r_state     <= StOver;
                        end else begin
                           r_turn  <= r_cur_o ? TURN_X : TURN_O;
                           r_state <= StWaitMove;
                        end
                     end
                  end else begin
                     r_tmo <= r_tmo + TMO_W'(1);
                  end
               end

               StOver: begin
                  r_turn <= TURN_NONE;
               end

               default: r_state <= StWaitMove;
            endcase
         end
      end
   end

   assign o_px_ack     = r_px_ack;
   assign o_po_ack     = r_po_ack;
   assign o_move_err   = r_move_err;
   assign o_core_valid = r_core_valid;
   assign o_core_xoro  = r_core_xoro;
   assign o_core_row   = r_core_row;
   assign o_core_col   = r_core_col;
   assign o_core_ai_en = r_core_ai_en;
   assign o_turn       = r_turn;
   assign o_move_cnt   = r_move_cnt;
   assign o_game_over  = r_game_over;
   assign o_winner     = r_winner;
   assign o_draw       = r_draw;
   assign o_ai_fault   = r_ai_fault;

   // Protocol invariants of the registered outputs.
   a_no_ack_with_valid : assert property (@(posedge i_clk) disable iff (i_reset)
      !(r_core_valid && (r_px_ack || r_po_ack)));
   a_err_with_ack : assert property (@(posedge i_clk) disable iff (i_reset)
      !r_move_err || r_px_ack || r_po_ack);
   a_over_turn : assert property (@(posedge i_clk) disable iff (i_reset)
      r_game_over == (r_turn == TURN_NONE));

endmodule
